hash_request_stage: RTL

//  Upstream feeder of the cuckoo-hash controller. Buffers host requests (key, data, op) in a small FIFO.

---
 rtl/hash_pkg.sv | 29 ++
 rtl/hash_request_fifo.sv | 57 +++++
 rtl/hash_request_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// Shared op encoding and H3 hash helpers for the cuckoo-hash request path.
package hash_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  localparam int STAT_W = 16;

  // H3 matrix entry for table t, key bit b (before reduction to the address width).
  function automatic int h3_const(input int t, input int b);
    return (b + 1) * (2 * t + 3) + t;
  endfunction

  // XOR of the H3 entries of every set key bit, reduced modulo 2^adr_w.
  function automatic logic [31:0] h3_hash(input logic [31:0] key, input int key_w,
                                          input int t, input int adr_w);
    logic [31:0] acc;
    acc = '0;
    for (int b = 0; b < key_w; b++) begin
      if (key[b[4:0]]) acc ^= 32'(h3_const(t, b));
    end
    return acc & ((32'd1 << adr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/hash_request_fifo.sv
// Generic synchronous FIFO with async active-high reset; DEPTH must be a power of 2.
module request_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // Pointers wrap naturally because DEPTH is a power of 2.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/hash_request_stage.sv
// Request FIFO + H3 hash + registered command output for the cuckoo-hash controller.
// Optional request statistics counters are built when REQ_STATS_EN is defined.
module hash_request_stage
  import hash_pkg::*;
#(
  parameter int KEY_WIDTH           = 4,
  parameter int DATA_WIDTH          = 8,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 4,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [KEY_WIDTH-1:0]          req_key_i,
  input  logic [DATA_WIDTH-1:0]         req_data_i,
  input  logic [1:0]                    req_op_i,
  input  logic                          ctrl_ready_i,
  output logic [KEY_WIDTH-1:0]          key_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0] hash_adr_o,
  output logic [1:0]                    delete_write_read_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef REQ_STATS_EN
  ,
  output logic [STAT_W-1:0]             stat_accepted_o,
  output logic [STAT_W-1:0]             stat_stall_o
`endif
);

  localparam int ENTRY_W = KEY_WIDTH + DATA_WIDTH + 2;

  logic [ENTRY_W-1:0]    head;
  logic [KEY_WIDTH-1:0]  head_key;
  logic [DATA_WIDTH-1:0] head_data;
  op_e                   head_op;
  logic                  fifo_full, fifo_empty, push, load;
  logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0] head_hash;

  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0] hash_q, hash_d;
  op_e                   op_q, op_d;

  assign req_ready_o = !fifo_full && !rst;
  // NOP requests are acknowledged but never buffered.
  assign push = req_valid_i && req_ready_o && (op_e'(req_op_i) != OP_NOP);
  assign load = !fifo_empty && ((op_q == OP_NOP) || ctrl_ready_i);

  request_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (load),
    .din_i   ({req_key_i, req_data_i, req_op_i}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign head_key  = head[ENTRY_W-1 -: KEY_WIDTH];
  assign head_data = head[2 +: DATA_WIDTH];
  assign head_op   = op_e'(head[1:0]);

  for (genvar t = 0; t < NUMBER_OF_TABLES; t++) begin : g_hash
    assign head_hash[t] = HASH_TABLE_MAX_SIZE'(
      h3_hash(32'(head_key), KEY_WIDTH, t, HASH_TABLE_MAX_SIZE));
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    key_d  = key_q;
    data_d = data_q;
    hash_d = hash_q;
    op_d   = op_q;
    if (load) begin
      key_d  = head_key;
      data_d = head_data;
      hash_d = head_hash;
      op_d   = head_op;
    end else if (ctrl_ready_i) begin
      op_d   = OP_NOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= '0;
      data_q <= '0;
      hash_q <= '0;
      op_q   <= OP_NOP;
    end else begin
      key_q  <= key_d;
      data_q <= data_d;
      hash_q <= hash_d;
      op_q   <= op_d;
    end
  end

  assign key_o               = key_q;
  assign data_o              = data_q;
  assign hash_adr_o          = hash_q;
  assign delete_write_read_o = op_q;

`ifdef REQ_STATS_EN
  logic [STAT_W-1:0] accepted_q, accepted_d, stall_q, stall_d;

  always_comb begin
    accepted_d = accepted_q;
    stall_d    = stall_q;
    if (push && (accepted_q != '1))                      accepted_d = accepted_q + 1'b1;
    if (req_valid_i && !req_ready_o && (stall_q != '1))  stall_d    = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_q <= '0;
      stall_q    <= '0;
    end else begin
      accepted_q <= accepted_d;
      stall_q    <= stall_d;
    end
  end

  assign stat_accepted_o = accepted_q;
  assign stat_stall_o    = stall_q;
`endif

endmodule
